// File: rtl/riscv_bp_pkg.sv
// Shared types and helpers for the BTB/BHT branch predictor.
// Field extraction and counter constants are width-parametric functions so every table size shares one definition.
package riscv_bp_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] xlen_t;
   typedef logic [XLEN-1:2] target_t;

   // Reset value: weakly not-taken.
   function automatic int unsigned ctrInit(input int unsigned bits);
      return (32'd1 << (bits - 1)) - 32'd1;
   endfunction

   // Conditional-branch allocation value: weakly taken.
   function automatic int unsigned ctrWeakTaken(input int unsigned bits);
      return 32'd1 << (bits - 1);
   endfunction

   function automatic int unsigned ctrMax(input int unsigned bits);
      return (32'd1 << bits) - 32'd1;
   endfunction

   function automatic xlen_t pcIndex(input xlen_t pc, input int unsigned idxBits);
      return (pc >> 2) & ((32'd1 << idxBits) - 32'd1);
   endfunction

   function automatic xlen_t pcTag(input xlen_t pc, input int unsigned idxBits,
                                   input int unsigned tagBits);
      return xlen_t'((64'(pc) >> (idxBits + 2)) & ((64'd1 << tagBits) - 64'd1));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with parallel load; one per predictor entry.
// Latency: one clock from inc/dec/load to count; load has priority over inc, inc over dec.
// No backpressure: the counter accepts a command every cycle.
module sat_counter #(
   parameter int               WIDTH = 2,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= INIT;
      else if (load)
         count <= loadValue;
      else if (inc && (count != '1))
         count <= count + 1'b1;
      else if (dec && (count != '0))
         count <= count - 1'b1;
   end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating counters; zero-cycle lookup, update and redirect from MEM.
// No backpressure; optional statistics counters are built only when BRANCH_PRED_STATS_EN is defined.
module branch_predictor_btb
   import riscv_bp_pkg::*;
#(
   parameter int ENTRIES      = 16,
   parameter int TAG_BITS     = 8,
   parameter int COUNTER_BITS = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc_if,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_is_cond,
   input  logic        upd_is_jalr,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispred
);

   localparam int IDX_BITS = $clog2(ENTRIES);

   typedef logic [IDX_BITS-1:0]     idx_t;
   typedef logic [TAG_BITS-1:0]     tag_t;
   typedef logic [COUNTER_BITS-1:0] ctr_t;

   localparam ctr_t CTR_INIT = ctr_t'(ctrInit(COUNTER_BITS));
   localparam ctr_t CTR_WEAK = ctr_t'(ctrWeakTaken(COUNTER_BITS));
   localparam ctr_t CTR_MAX  = ctr_t'(ctrMax(COUNTER_BITS));

   logic [ENTRIES-1:0] validQ;
   tag_t               tagQ    [ENTRIES];
   target_t            targetQ [ENTRIES];
   ctr_t               countQ  [ENTRIES];

   idx_t lookIdx, updIdx;
   tag_t lookTag, updTag;
   logic lookHit, updHit, updWrite;

   assign lookIdx = idx_t'(pcIndex(pc_if, IDX_BITS));
   assign lookTag = tag_t'(pcTag(pc_if, IDX_BITS, TAG_BITS));
   assign updIdx  = idx_t'(pcIndex(upd_pc, IDX_BITS));
   assign updTag  = tag_t'(pcTag(upd_pc, IDX_BITS, TAG_BITS));

   assign lookHit  = validQ[lookIdx] && (tagQ[lookIdx] == lookTag);
   assign updHit   = validQ[updIdx] && (tagQ[updIdx] == updTag);
   // jalr targets come from a register, so they are never cached.
   assign updWrite = upd_valid && !upd_is_jalr;

   assign pred_taken  = lookHit && countQ[lookIdx][COUNTER_BITS-1];
   assign pred_target = pred_taken ? {targetQ[lookIdx], 2'b00} : pc_if + 32'd4;

   assign mispredict  = upd_valid && ((upd_pred_taken != upd_taken) ||
                                      (upd_taken && (upd_pred_target != upd_target)));
   assign redirect_pc = (upd_valid && upd_taken) ? {upd_target[31:1], 1'b0}
                                                 : upd_pc + 32'd4;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         validQ <= '0;
      else if (updWrite && upd_taken)
         validQ[updIdx] <= 1'b1;
   end

   // A taken update either refreshes a hit or allocates over whatever alias held the slot.
   always_ff @(posedge clock) begin
      if (updWrite && upd_taken) begin
         tagQ[updIdx]    <= updTag;
         targetQ[updIdx] <= upd_target[31:2];
      end
   end

   for (genvar i = 0; i < ENTRIES; i++) begin : gEntry
      logic sel;
      assign sel = updWrite && (updIdx == idx_t'(i));

      sat_counter #(.WIDTH(COUNTER_BITS), .INIT(CTR_INIT)) uCounter (
         .clock     (clock),
         .reset     (reset),
         .inc       (sel && updHit && upd_taken),
         .dec       (sel && updHit && !upd_taken),
         .load      (sel && !updHit && upd_taken),
         .loadValue (upd_is_cond ? CTR_WEAK : CTR_MAX),
         .count     (countQ[i])
      );
   end

`ifdef BRANCH_PRED_STATS_EN
   logic [31:0] branchesQ, mispredQ;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         branchesQ <= '0;
         mispredQ  <= '0;
      end else begin
         if (upd_valid && (branchesQ != '1))
            branchesQ <= branchesQ + 32'd1;
         if (mispredict && (mispredQ != '1))
            mispredQ <= mispredQ + 32'd1;
      end
   end

   assign stat_branches = branchesQ;
   assign stat_mispred  = mispredQ;
`else
   assign stat_branches = '0;
   assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed vectors for branch_predictor_btb; expected responses are queued at issue
// and compared by an independent negedge monitor.
module tb_branch_predictor_btb;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pc_if;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid, upd_is_cond, upd_is_jalr, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc, stat_branches, stat_mispred;

   branch_predictor_btb dut (
      .clock           (clock),
      .reset           (reset),
      .pc_if           (pc_if),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_is_cond     (upd_is_cond),
      .upd_is_jalr     (upd_is_jalr),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc),
      .stat_branches   (stat_branches),
      .stat_mispred    (stat_mispred)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          id;
      logic        pt;
      logic [31:0] ptg;
      logic        mis;
      logic [31:0] rd;
      logic [31:0] br;
      logic [31:0] mp;
   } exp_t;

   exp_t        expQ[$];
   int          checks = 0;
   int          errors = 0;
   int          vecId  = 0;
   logic [31:0] expBr  = 0;
   logic [31:0] expMp  = 0;

   task automatic chk(input int id, input string what, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL vec %0d %s: got 0x%08h expected 0x%08h", id, what, act, req);
      end
   endtask

   always @(negedge clock) begin
      while (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         chk(e.id, "pred_taken",    {31'd0, pred_taken}, {31'd0, e.pt});
         chk(e.id, "pred_target",   pred_target,         e.ptg);
         chk(e.id, "mispredict",    {31'd0, mispredict}, {31'd0, e.mis});
         chk(e.id, "redirect_pc",   redirect_pc,         e.rd);
         chk(e.id, "stat_branches", stat_branches,       e.br);
         chk(e.id, "stat_mispred",  stat_mispred,        e.mp);
      end
   end

   // Called just after a rising edge; holds inputs for one full cycle.
   task automatic vec(input logic [31:0] pcIf, input logic v, input logic [31:0] pc,
                      input logic cond, input logic jalr, input logic tk,
                      input logic [31:0] tgt, input logic ppt, input logic [31:0] ppg,
                      input logic ePt, input logic [31:0] ePtg,
                      input logic eMis, input logic [31:0] eRd);
      exp_t e;
      pc_if = pcIf;       upd_valid = v;       upd_pc = pc;
      upd_is_cond = cond; upd_is_jalr = jalr;  upd_taken = tk;
      upd_target = tgt;   upd_pred_taken = ppt; upd_pred_target = ppg;
      e.id = vecId; e.pt = ePt; e.ptg = ePtg; e.mis = eMis; e.rd = eRd;
`ifdef BRANCH_PRED_STATS_EN
      e.br = expBr; e.mp = expMp;
`else
      e.br = 32'd0; e.mp = 32'd0;
`endif
      expQ.push_back(e);
      if (v)    expBr++;
      if (eMis) expMp++;
      vecId++;
      @(posedge clock);
      #1;
   endtask

   task automatic look(input logic [31:0] pcIf, input logic ePt, input logic [31:0] ePtg);
      vec(pcIf, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, ePt, ePtg, 1'b0, 32'd4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      pc_if = 0; upd_valid = 0; upd_pc = 0; upd_is_cond = 0; upd_is_jalr = 0;
      upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Cold table
      look(32'h40, 0, 32'h44);
      // blt 0x40 taken: miss allocates weakly taken
      vec(32'h40, 1, 32'h40, 1, 0, 1, 32'h20, 0, 32'h44, 0, 32'h44, 1, 32'h20);
      look(32'h40, 1, 32'h20);
      // Not-taken updates: 10 -> 01 -> 00 -> 00
      vec(32'h40, 1, 32'h40, 1, 0, 0, 32'h20, 1, 32'h20, 1, 32'h20, 1, 32'h44);
      vec(32'h40, 1, 32'h40, 1, 0, 0, 32'h20, 0, 32'h44, 0, 32'h44, 0, 32'h44);
      vec(32'h40, 1, 32'h40, 1, 0, 0, 32'h20, 0, 32'h44, 0, 32'h44, 0, 32'h44);
      look(32'h40, 0, 32'h44);
      // jal 0x80 aliases index 0: allocates strongly taken, evicts 0x40
      vec(32'h80, 1, 32'h80, 0, 0, 1, 32'h100, 0, 32'h84, 0, 32'h84, 1, 32'h100);
      look(32'h80, 1, 32'h100);
      look(32'hC0, 0, 32'hC4);
      look(32'h40, 0, 32'h44);
      // Four not-taken conds at 0x80: 11 -> 10 -> 01 -> 00 -> 00
      vec(32'h80, 1, 32'h80, 1, 0, 0, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h84);
      vec(32'h80, 1, 32'h80, 1, 0, 0, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h84);
      vec(32'h80, 1, 32'h80, 1, 0, 0, 32'h100, 0, 32'h84, 0, 32'h84, 0, 32'h84);
      vec(32'h80, 1, 32'h80, 1, 0, 0, 32'h100, 0, 32'h84, 0, 32'h84, 0, 32'h84);
      look(32'h80, 0, 32'h84);
      // jalr: LSB cleared on redirect, never allocated
      vec(32'h90, 1, 32'h90, 0, 1, 1, 32'h105, 0, 32'h94, 0, 32'h94, 1, 32'h104);
      look(32'h90, 0, 32'h94);
      // Target mismatch with correct direction still mispredicts
      vec(32'h48, 1, 32'h48, 1, 0, 1, 32'h200, 0, 32'h4C, 0, 32'h4C, 1, 32'h200);
      vec(32'h48, 1, 32'h48, 1, 0, 1, 32'h200, 1, 32'h204, 1, 32'h200, 1, 32'h200);
      vec(32'h48, 1, 32'h48, 1, 0, 1, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h200);
      // Reset mid-stream clears the trained entry and stats
      reset = 1'b1;
      expBr = 0; expMp = 0;
      look(32'h48, 0, 32'h4C);
      reset = 1'b0;
      look(32'h48, 0, 32'h4C);
      vec(32'h48, 1, 32'h48, 1, 0, 1, 32'h200, 0, 32'h4C, 0, 32'h4C, 1, 32'h200);
      vec(32'h48, 1, 32'h48, 1, 0, 1, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h200);
      vec(32'h90, 1, 32'h90, 0, 1, 1, 32'h105, 0, 32'h94, 0, 32'h94, 1, 32'h104);
      look(32'h48, 1, 32'h200);

      @(negedge clock);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations unchecked, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
